// File: rtl/if_pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : if_pc_fetch_ctrl
// Brief    : Instruction-fetch stage. Holds the PC, drives imem and loads IF/ID.
//            Handles EX-stage redirects, flushing, and halting on a misaligned target.
// Revision : 1.0 - initial release
// ============================================================================
module if_pc_fetch_ctrl #(
    parameter logic [31:0] RESET_ADDR = 32'h0040_0000,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             br_jmp_taken,
    input  logic [31:0]      jmp_br_addr,
    input  logic             stall,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      imem_addr,
    output logic [31:0]      if_id_pc,
    output logic [31:0]      if_id_pc4,
    output logic [31:0]      if_id_instr,
    output logic             if_id_valid,
    output logic             fetch_halted,
    output logic [CNT_W-1:0] redirect_cnt
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      ifid_pc_q, ifid_pc_d;
    logic [31:0]      ifid_pc4_q, ifid_pc4_d;
    logic [31:0]      ifid_instr_q, ifid_instr_d;
    logic             ifid_valid_q, ifid_valid_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0]      w_pc_plus4;
    logic             w_misaligned;
    logic             w_flush;

    assign w_pc_plus4   = pc_q + 32'd4;
    assign w_misaligned = (jmp_br_addr[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_ADDR;
            ifid_pc_q    <= 32'h0;
            ifid_pc4_q   <= 32'h0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
            halted_q     <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            halted_q     <= halted_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        halted_d     = halted_q;
        cnt_d        = cnt_q;
        w_flush      = 1'b0;

        case (state_q)
            // One idle cycle after reset so imem sees a stable address first.
            ST_BOOT: begin
                state_d = ST_RUN;
                w_flush = 1'b1;
            end
            ST_RUN: begin
                if (br_jmp_taken && w_misaligned) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                    w_flush  = 1'b1;
                end else if (br_jmp_taken) begin
                    pc_d    = jmp_br_addr;
                    w_flush = 1'b1;
                    if (cnt_q != c_CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (!stall) begin
                    pc_d         = w_pc_plus4;
                    ifid_pc_d    = pc_q;
                    ifid_pc4_d   = w_pc_plus4;
                    ifid_instr_d = imem_rdata;
                    ifid_valid_d = 1'b1;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_BOOT;
                w_flush = 1'b1;
            end
        endcase

        if (w_flush) begin
            ifid_pc_d    = 32'h0;
            ifid_pc4_d   = 32'h0;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
        end
    end

    assign imem_addr    = pc_q;
    assign if_id_pc     = ifid_pc_q;
    assign if_id_pc4    = ifid_pc4_q;
    assign if_id_instr  = ifid_instr_q;
    assign if_id_valid  = ifid_valid_q;
    assign fetch_halted = halted_q;
    assign redirect_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_if_pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_pc_fetch_ctrl
// Brief    : Directed and randomized bench for if_pc_fetch_ctrl with a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_pc_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        br_jmp_taken = 1'b0;
    logic [31:0] jmp_br_addr = 32'h0;
    logic        stall = 1'b0;

    logic [31:0] imem_rdata, imem_addr, if_id_pc, if_id_pc4, if_id_instr;
    logic        if_id_valid, fetch_halted;
    logic [15:0] redirect_cnt;

    logic [31:0] s_rdata, s_addr, s_pc, s_pc4, s_instr;
    logic        s_valid, s_halted;
    logic [1:0]  s_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = mem_word(imem_addr);
    assign s_rdata    = mem_word(s_addr);

    if_pc_fetch_ctrl #(.RESET_ADDR(RST_PC), .NOP_INSTR(NOP), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .br_jmp_taken(br_jmp_taken), .jmp_br_addr(jmp_br_addr),
        .stall(stall), .imem_rdata(imem_rdata), .imem_addr(imem_addr), .if_id_pc(if_id_pc),
        .if_id_pc4(if_id_pc4), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
        .fetch_halted(fetch_halted), .redirect_cnt(redirect_cnt)
    );

    if_pc_fetch_ctrl #(.RESET_ADDR(RST_PC), .NOP_INSTR(NOP), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .br_jmp_taken(br_jmp_taken), .jmp_br_addr(jmp_br_addr),
        .stall(stall), .imem_rdata(s_rdata), .imem_addr(s_addr), .if_id_pc(s_pc),
        .if_id_pc4(s_pc4), .if_id_instr(s_instr), .if_id_valid(s_valid),
        .fetch_halted(s_halted), .redirect_cnt(s_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: fetch stage described as "booting / halted / running" flags.
    logic [31:0] m_pc, m_ipc, m_ipc4, m_instr;
    logic        m_valid, m_halt, m_boot;
    int          m_cnt, m_cnt2;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_pc = RST_PC; m_ipc = 0; m_ipc4 = 0; m_instr = NOP; m_valid = 0;
            m_halt = 0; m_boot = 1; m_cnt = 0; m_cnt2 = 0;
        end else if (m_boot) begin
            m_boot = 0;
        end else if (m_halt) begin
            m_halt = 1;
        end else if (br_jmp_taken) begin
            m_ipc = 0; m_ipc4 = 0; m_instr = NOP; m_valid = 0;
            if (jmp_br_addr % 4 != 0) begin
                m_halt = 1;
            end else begin
                m_pc   = jmp_br_addr;
                m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : 65535;
                m_cnt2 = (m_cnt2 < 3)     ? m_cnt2 + 1 : 3;
            end
        end else if (!stall) begin
            m_ipc   = m_pc;
            m_ipc4  = m_pc + 32'd4;
            m_instr = mem_word(m_pc);
            m_valid = 1;
            m_pc    = m_pc + 32'd4;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] exp_seq [3];
        exp_seq = '{32'h0040_0000, 32'h0040_0004, 32'h0040_0008};
        rst_n = 0; br_jmp_taken = 0; stall = 0;
        tick();
        n_cmp++; if (imem_addr !== RST_PC) begin n_fail++; $display("FAIL reset_pc got %h exp %h", imem_addr, RST_PC); end
        n_cmp++; if (if_id_instr !== NOP || if_id_valid !== 1'b0 || if_id_pc !== 0 || if_id_pc4 !== 0) begin
            n_fail++; $display("FAIL reset_ifid got pc=%h pc4=%h instr=%h v=%b", if_id_pc, if_id_pc4, if_id_instr, if_id_valid); end
        n_cmp++; if (fetch_halted !== 1'b0 || redirect_cnt !== 16'd0) begin
            n_fail++; $display("FAIL reset_flags got halted=%b cnt=%0d exp 0/0", fetch_halted, redirect_cnt); end
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (imem_addr !== exp_seq[i]) begin n_fail++; $display("FAIL boot_seq%0d got %h exp %h", i, imem_addr, exp_seq[i]); end
            if (i == 1) begin
                n_cmp++; if (if_id_valid !== 1'b1 || if_id_pc !== RST_PC || if_id_instr !== mem_word(RST_PC)) begin
                    n_fail++; $display("FAIL first_valid got v=%b pc=%h instr=%h exp pc %h", if_id_valid, if_id_pc, if_id_instr, RST_PC); end
            end
        end
    endtask

    task automatic test_redirect();
        br_jmp_taken = 1; jmp_br_addr = 32'h0040_0100;
        tick();
        br_jmp_taken = 0;
        n_cmp++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP || imem_addr !== 32'h0040_0100) begin
            n_fail++; $display("FAIL redir_flush got v=%b instr=%h addr=%h", if_id_valid, if_id_instr, imem_addr); end
        n_cmp++; if (redirect_cnt !== 16'd1) begin n_fail++; $display("FAIL redir_cnt got %0d exp 1", redirect_cnt); end
        tick();
        n_cmp++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0040_0100 || if_id_pc4 !== 32'h0040_0104) begin
            n_fail++; $display("FAIL redir_target got v=%b pc=%h pc4=%h", if_id_valid, if_id_pc, if_id_pc4); end
    endtask

    task automatic test_stall();
        br_jmp_taken = 1; jmp_br_addr = 32'h0040_000C;
        tick();
        br_jmp_taken = 0; stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (imem_addr !== 32'h0040_000C || if_id_valid !== 1'b0 || if_id_instr !== NOP) begin
                n_fail++; $display("FAIL stall_hold%0d got addr=%h v=%b instr=%h", i, imem_addr, if_id_valid, if_id_instr); end
        end
        stall = 0;
        tick();
        n_cmp++; if (if_id_pc !== 32'h0040_000C || if_id_valid !== 1'b1 || imem_addr !== 32'h0040_0010) begin
            n_fail++; $display("FAIL stall_release got pc=%h v=%b addr=%h", if_id_pc, if_id_valid, imem_addr); end
        tick();
        n_cmp++; if (if_id_pc !== 32'h0040_0010) begin n_fail++; $display("FAIL stall_nodup got %h exp 00400010", if_id_pc); end
    endtask

    task automatic test_stall_redirect();
        stall = 1; br_jmp_taken = 1; jmp_br_addr = 32'h0040_0200;
        tick();
        stall = 0; br_jmp_taken = 0;
        n_cmp++; if (imem_addr !== 32'h0040_0200 || if_id_valid !== 1'b0 || if_id_pc !== 0 || redirect_cnt !== 16'd3) begin
            n_fail++; $display("FAIL stall_redir got addr=%h v=%b pc=%h cnt=%0d", imem_addr, if_id_valid, if_id_pc, redirect_cnt); end
    endtask

    task automatic test_misaligned();
        tick();
        br_jmp_taken = 1; jmp_br_addr = 32'h0040_0102;
        tick();
        n_cmp++; if (fetch_halted !== 1'b1 || if_id_valid !== 1'b0 || imem_addr !== 32'h0040_0204 || redirect_cnt !== 16'd3) begin
            n_fail++; $display("FAIL halt_entry got h=%b v=%b addr=%h cnt=%0d", fetch_halted, if_id_valid, imem_addr, redirect_cnt); end
        jmp_br_addr = 32'h0040_0300;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (imem_addr !== 32'h0040_0204 || if_id_valid !== 1'b0 || redirect_cnt !== 16'd3) begin
                n_fail++; $display("FAIL halt_ignore%0d got addr=%h v=%b cnt=%0d", i, imem_addr, if_id_valid, redirect_cnt); end
        end
        br_jmp_taken = 0; rst_n = 0;
        tick();
        n_cmp++; if (imem_addr !== RST_PC || fetch_halted !== 1'b0 || redirect_cnt !== 16'd0) begin
            n_fail++; $display("FAIL halt_reset got addr=%h h=%b cnt=%0d", imem_addr, fetch_halted, redirect_cnt); end
        rst_n = 1;
    endtask

    task automatic test_wrap();
        tick();
        br_jmp_taken = 1; jmp_br_addr = 32'hFFFF_FFFC;
        tick();
        br_jmp_taken = 0;
        n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_target got %h exp fffffffc", imem_addr); end
        tick();
        n_cmp++; if (imem_addr !== 32'h0 || if_id_pc !== 32'hFFFF_FFFC || if_id_pc4 !== 32'h0) begin
            n_fail++; $display("FAIL wrap_pc got addr=%h pc=%h pc4=%h", imem_addr, if_id_pc, if_id_pc4); end
    endtask

    task automatic test_saturation();
        rst_n = 0;
        tick();
        rst_n = 1; br_jmp_taken = 1; jmp_br_addr = 32'h0050_0000;
        tick();
        n_cmp++; if (imem_addr !== RST_PC || redirect_cnt !== 16'd0) begin
            n_fail++; $display("FAIL boot_ignore got addr=%h cnt=%0d", imem_addr, redirect_cnt); end
        for (int k = 1; k <= 5; k++) begin
            jmp_br_addr = RST_PC + 32'(k * 16);
            tick();
            n_cmp++; if (s_cnt !== 2'((k > 3) ? 3 : k) || redirect_cnt !== 16'(k)) begin
                n_fail++; $display("FAIL sat_cnt%0d got narrow=%0d wide=%0d exp %0d/%0d", k, s_cnt, redirect_cnt, (k > 3) ? 3 : k, k); end
        end
        br_jmp_taken = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst_n        = ($urandom_range(0, 39) != 0);
            br_jmp_taken = ($urandom_range(0, 5) == 0);
            stall        = ($urandom_range(0, 3) == 0);
            jmp_br_addr  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            if ($urandom_range(0, 7) == 0) jmp_br_addr[1:0] = 2'($urandom_range(1, 3));
            tick();
            n_cmp++; if (imem_addr !== m_pc || if_id_pc !== m_ipc || if_id_pc4 !== m_ipc4 ||
                         if_id_instr !== m_instr || if_id_valid !== m_valid) begin
                n_fail++; $display("FAIL rand%0d_pipe got addr=%h pc=%h pc4=%h instr=%h v=%b exp %h %h %h %h %b",
                    i, imem_addr, if_id_pc, if_id_pc4, if_id_instr, if_id_valid, m_pc, m_ipc, m_ipc4, m_instr, m_valid); end
            n_cmp++; if (fetch_halted !== m_halt || redirect_cnt !== 16'(m_cnt) || s_cnt !== 2'(m_cnt2)) begin
                n_fail++; $display("FAIL rand%0d_flags got h=%b cnt=%0d cnt2=%0d exp %b %0d %0d",
                    i, fetch_halted, redirect_cnt, s_cnt, m_halt, m_cnt, m_cnt2); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        #2;
        test_reset();
        test_redirect();
        test_stall();
        test_stall_redirect();
        test_misaligned();
        test_wrap();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
